// File: rtl/probe_uplink_collector.sv
// Host-side probe link endpoint: registers downlink commands, frames uplink packets
// (header + N data words) and buffers accepted words in a FIFO toward the host stream.
module probe_uplink_collector #(
    parameter int unsigned FifoLog2 = 4,
    parameter int unsigned MaxWords = 8
) (
    input  logic        uclk_i,
    input  logic        urst_i,
    input  logic        hcmd_valid_i,
    input  logic [18:0] hcmd_i,
    output logic        hcmd_ready_o,
    output logic        cmden_o,
    output logic [18:0] cmd_o,
    input  logic [31:0] dataup_i,
    input  logic        datavalid_i,
    input  logic        delay_i,
    output logic        ack_o,
    output logic [31:0] out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        pending_o,
    output logic        frame_err_o,
    output logic [15:0] pkt_count_o
);

    localparam int unsigned Depth = 1 << FifoLog2;
    localparam int unsigned RemW  = $clog2(MaxWords + 1);
    localparam logic [7:0] MaxN = 8'(MaxWords);
    localparam logic [FifoLog2:0] PtrOne = 1;
    localparam logic [RemW-1:0] RemOne = 1;

    typedef enum logic [1:0] {StIdle, StData, StErrDrain} state_e;

    state_e            state_q, state_d;
    logic [RemW-1:0]   rem_q, rem_d;
    logic [15:0]       pkt_q, pkt_d;
    logic              err_q, err_d;
    logic [FifoLog2:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [31:0]       mem_q [Depth];
    logic              cmden_q, pending_q;
    logic [18:0]       cmd_q;

    logic       full, empty, pop, push, ack;
    logic [7:0] hdr_n;
    logic       hdr_ok;

    assign full  = (wptr_q[FifoLog2] != rptr_q[FifoLog2]) &&
                   (wptr_q[FifoLog2-1:0] == rptr_q[FifoLog2-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign pop   = !empty && out_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept a word.
    assign ack   = !urst_i && datavalid_i && ((state_q == StErrDrain) || !full || pop);
    assign push  = ack && (state_q != StErrDrain);

    assign hdr_n  = dataup_i[7:0];
    assign hdr_ok = (hdr_n != 8'd0) && (hdr_n <= MaxN);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pkt_d   = pkt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (ack) begin
                    if (hdr_ok) begin
                        rem_d   = RemW'(hdr_n);
                        state_d = StData;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StErrDrain;
                    end
                end
            end
            StData: begin
                if (!datavalid_i) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (ack) begin
                    rem_d = rem_q - RemOne;
                    if (rem_q == RemOne) begin
                        pkt_d   = pkt_q + 16'd1;
                        state_d = StIdle;
                    end
                end
            end
            StErrDrain: begin
                if (!datavalid_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) wptr_d = wptr_q + PtrOne;
        if (pop)  rptr_d = rptr_q + PtrOne;
    end

    always_ff @(posedge uclk_i or posedge urst_i) begin
        if (urst_i) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            pkt_q     <= '0;
            err_q     <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cmden_q   <= 1'b0;
            cmd_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            pkt_q     <= pkt_d;
            err_q     <= err_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cmden_q   <= hcmd_valid_i;
            pending_q <= delay_i;
            if (hcmd_valid_i) cmd_q <= hcmd_i;
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge uclk_i) begin
        if (push) mem_q[wptr_q[FifoLog2-1:0]] <= dataup_i;
    end

    assign hcmd_ready_o = !urst_i;
    assign cmden_o      = cmden_q;
    assign cmd_o        = cmd_q;
    assign ack_o        = ack;
    assign out_valid_o  = !empty;
    assign out_data_o   = empty ? '0 : mem_q[rptr_q[FifoLog2-1:0]];
    assign pending_o    = pending_q;
    assign frame_err_o  = err_q;
    assign pkt_count_o  = pkt_q;

endmodule

// File: tb/tb_probe_uplink_collector.sv
// Randomized bench for probe_uplink_collector against a packet-level reference model.
module tb_probe_uplink_collector;

    logic        uclk = 1'b0;
    logic        urst;
    logic        hcmd_valid;
    logic [18:0] hcmd;
    logic        hcmd_ready;
    logic        cmden;
    logic [18:0] cmd;
    logic [31:0] dataup;
    logic        datavalid;
    logic        delay;
    logic        ack;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        pending;
    logic        frame_err;
    logic [15:0] pkt_count;

    probe_uplink_collector #(.FifoLog2(4), .MaxWords(8)) dut (
        .uclk_i      (uclk),
        .urst_i      (urst),
        .hcmd_valid_i(hcmd_valid),
        .hcmd_i      (hcmd),
        .hcmd_ready_o(hcmd_ready),
        .cmden_o     (cmden),
        .cmd_o       (cmd),
        .dataup_i    (dataup),
        .datavalid_i (datavalid),
        .delay_i     (delay),
        .ack_o       (ack),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .pending_o   (pending),
        .frame_err_o (frame_err),
        .pkt_count_o (pkt_count)
    );

    always #5 uclk = ~uclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: host-visible FIFO contents plus packet framing progress.
    logic [31:0] mq[$];
    bit          m_in_data, m_drain, m_err, m_cmden, m_pending;
    int          m_left, m_pkts;
    logic [18:0] m_cmd;

    // Probe side: words still to be offered in the current burst.
    logic [31:0] burst[$];
    int          gap = 0;
    bit          auto_gen = 0;
    bit          cmd_rand = 0;
    int          ready_mode = 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_in_data = 0; m_drain = 0; m_err = 0; m_cmden = 0; m_pending = 0;
        m_left = 0; m_pkts = 0; m_cmd = '0;
    endtask

    function automatic logic [31:0] make_hdr(input int n);
        logic [31:0] w;
        w = $urandom;
        w[7:0] = n[7:0];
        return w;
    endfunction

    task automatic gen_burst();
        int kind, n, m;
        kind = $urandom_range(0, 9);
        if (kind < 6) begin
            for (int p = 0; p < $urandom_range(1, 3); p++) begin
                n = $urandom_range(1, 8);
                burst.push_back(make_hdr(n));
                for (int i = 0; i < n; i++) burst.push_back($urandom);
            end
        end else if (kind < 8) begin
            n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 255);
            burst.push_back(make_hdr(n));
            for (int i = 0; i < $urandom_range(0, 3); i++) burst.push_back($urandom);
        end else begin
            n = $urandom_range(2, 8);
            m = $urandom_range(0, n - 1);
            burst.push_back(make_hdr(n));
            for (int i = 0; i < m; i++) burst.push_back($urandom);
        end
    endtask

    task automatic apply_probe();
        datavalid = (burst.size() != 0);
        dataup    = datavalid ? burst[0] : $urandom;
    endtask

    task automatic drive_inputs();
        if (burst.size() == 0) begin
            if (gap > 0) gap--;
            else if (auto_gen) begin
                gen_burst();
                gap = $urandom_range(1, 4);
            end
        end
        apply_probe();
        unique case (ready_mode)
            1:       out_ready = 1'b1;
            2:       out_ready = 1'b0;
            3:       out_ready = ($urandom_range(0, 7) == 0);
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        delay = $urandom_range(0, 1);
        if (cmd_rand) begin
            hcmd_valid = ($urandom_range(0, 2) == 0);
            hcmd       = 19'($urandom);
        end else begin
            hcmd_valid = 1'b0;
        end
    endtask

    // One link cycle: compare outputs mid-cycle, advance the model, re-drive after the edge.
    task automatic cycle();
        bit pop_e, ack_e;
        int sz, n;
        @(negedge uclk);
        sz    = mq.size();
        pop_e = (sz > 0) && out_ready;
        ack_e = datavalid && (m_drain || sz < 16 || pop_e);
        check_eq("ack", ack, ack_e);
        check_eq("hcmd_ready", hcmd_ready, 1);
        check_eq("out_valid", out_valid, sz > 0);
        if (sz > 0) check_eq("out_data", out_data, mq[0]);
        check_eq("cmden", cmden, m_cmden);
        check_eq("cmd", cmd, m_cmd);
        check_eq("frame_err", frame_err, m_err);
        check_eq("pkt_count", pkt_count, m_pkts);
        check_eq("pending", pending, m_pending);

        if (pop_e) void'(mq.pop_front());
        if (ack_e && !m_drain) mq.push_back(dataup);
        if (!datavalid) begin
            if (m_in_data) m_err = 1;
            m_in_data = 0;
            m_drain   = 0;
        end else if (ack_e && !m_drain) begin
            if (m_in_data) begin
                m_left--;
                if (m_left == 0) begin
                    m_pkts    = (m_pkts + 1) % 65536;
                    m_in_data = 0;
                end
            end else begin
                n = dataup[7:0];
                if (n >= 1 && n <= 8) begin
                    m_in_data = 1;
                    m_left    = n;
                end else begin
                    m_err   = 1;
                    m_drain = 1;
                end
            end
        end
        m_cmden   = hcmd_valid;
        if (hcmd_valid) m_cmd = hcmd;
        m_pending = delay;
        if (ack_e) void'(burst.pop_front());

        @(posedge uclk);
        #1;
        drive_inputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        urst = 1'b1; hcmd_valid = 0; hcmd = '0; dataup = '0; datavalid = 0;
        delay = 0; out_ready = 0;
        model_reset();
        repeat (2) @(posedge uclk);
        #1;
        check_eq("rst_hcmd_ready", hcmd_ready, 0);
        check_eq("rst_ack", ack, 0);
        check_eq("rst_cmden", cmden, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_pkt_count", pkt_count, 0);
        urst = 1'b0;

        // Single command plus a well-formed two-word packet.
        hcmd_valid = 1'b1;
        hcmd       = 19'h0001A;
        burst      = '{32'h0007_0002, 32'hDEADBEEF, 32'h12345678};
        out_ready  = 1'b1;
        apply_probe();
        run(6);
        check_eq("t1_cmd", cmd, 19'h0001A);
        check_eq("t2_pkts", pkt_count, 1);

        // Five N=3 packets against a stalled host.
        ready_mode = 2;
        for (int p = 0; p < 5; p++) begin
            burst.push_back(make_hdr(3));
            for (int i = 0; i < 3; i++) burst.push_back($urandom);
        end
        apply_probe();
        run(25);
        check_eq("t3_full_ack", ack, 0);
        ready_mode = 1;
        run(30);
        check_eq("t3_pkts", pkt_count, 6);

        // Zero-length header, junk, then a good packet.
        burst = '{32'h0001_0000, 32'h1111_1103, 32'h2222_2201, 32'h3333_3302};
        apply_probe();
        run(7);
        burst = '{32'h0009_0001, 32'hCAFEF00D};
        apply_probe();
        run(6);
        check_eq("t4_err", frame_err, 1);
        check_eq("t4_pkts", pkt_count, 7);

        // Truncated packet.
        burst = '{32'h0000_0002, 32'h5555_AAAA};
        apply_probe();
        run(6);
        check_eq("t5_pkts", pkt_count, 7);

        auto_gen   = 1;
        cmd_rand   = 1;
        for (int blk = 0; blk < 40; blk++) begin
            ready_mode = $urandom_range(0, 3);
            run(64);
        end

        // Asynchronous reset between edges, likely mid-packet.
        #2;
        urst = 1'b1;
        #1;
        check_eq("arst_ack", ack, 0);
        check_eq("arst_cmden", cmden, 0);
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_frame_err", frame_err, 0);
        @(posedge uclk);
        #1;
        check_eq("arst_pkt_count", pkt_count, 0);
        urst = 1'b0;
        model_reset();
        run(1);
        for (int blk = 0; blk < 20; blk++) begin
            ready_mode = $urandom_range(0, 3);
            run(64);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
